// File: rtl/reg_dump_pkg.sv
// ---------------------------------------------------------------------------
// reg_dump_pkg
//   Shared definitions for the register-dump controller: default widths,
//   default register-file read latency and the controller state encoding.
// ---------------------------------------------------------------------------
package reg_dump_pkg;

    localparam int DATA_W_DEF   = 32;  // width of one register word
    localparam int ADDR_W_DEF   = 5;   // register-file address width
    localparam int READ_LAT_DEF = 0;   // register-file read latency, 0..3

    typedef enum logic [2:0] {
        IDLE,   // waiting for start
        ISSUE,  // read address presented to the register file
        WAIT,   // waiting out the register-file read latency
        OUT,    // beat presented, waiting for dump_ready
        FIN     // end of dump: done pulse, halt released
    } dump_state_t;

endpackage

// File: rtl/reg_dump_ctrl.sv
// ---------------------------------------------------------------------------
// reg_dump_ctrl
//   Halts the processor and streams a range of register-file words out over
//   a valid/ready interface, one read outstanding at a time. Optionally
//   repeats the range until stop is seen.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              request a dump (sampled in IDLE only)
//   continuous         repeat passes until stop (sampled with start)
//   stop               finish continuous mode after the current pass
//   first_addr, count  first register and number of registers (with start)
//   reg_addr/reg_data  register-file debug read port
//   halt_req           processor halt request for the duration of the dump
//   dump_valid/ready   output handshake
//   dump_data/addr     captured word and its address
//   dump_last          final beat of a pass
//   busy               controller not in IDLE
//   done               one-cycle pulse when the dump ends
// ---------------------------------------------------------------------------
module reg_dump_ctrl
    import reg_dump_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int READ_LAT = READ_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              continuous,
    input  logic              stop,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] reg_addr,
    input  logic [DATA_W-1:0] reg_data,
    output logic              halt_req,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              dump_last,
    output logic              busy,
    output logic              done
);

    // Number of registers in the file; larger counts are clipped to this.
    localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
    // WAIT counts down to zero; the read data is captured on the zero cycle.
    localparam logic [1:0]      WAIT_INIT = (READ_LAT > 0) ? 2'(READ_LAT - 1) : 2'd0;

    dump_state_t       state;
    logic [ADDR_W-1:0] addr;       // address of the read in flight
    logic [ADDR_W-1:0] first_q;    // reload point for continuous passes
    logic [ADDR_W:0]   count_q;    // beats per pass, already saturated
    logic [ADDR_W:0]   beat;       // 1-based beat number within the pass
    logic              cont_q;
    logic              stop_q;
    logic [1:0]        wait_cnt;
    logic [ADDR_W:0]   count_sat;
    logic              capture;

    assign count_sat = (count > DEPTH) ? DEPTH : count;

    // Read data is valid at the end of ISSUE for a zero-latency file,
    // otherwise at the end of the final WAIT cycle.
    assign capture = ((state == ISSUE) && (READ_LAT == 0)) ||
                     ((state == WAIT)  && (wait_cnt == 2'd0));

    // NOTE: every register here uses non-blocking assignment so all state
    // updates see the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the datapath registers (dump_data, reg_addr) are reset
            // too, because all outputs must read zero while reset is held.
            state      <= IDLE;
            addr       <= '0;
            first_q    <= '0;
            count_q    <= '0;
            beat       <= '0;
            cont_q     <= 1'b0;
            stop_q     <= 1'b0;
            wait_cnt   <= '0;
            reg_addr   <= '0;
            halt_req   <= 1'b0;
            dump_valid <= 1'b0;
            dump_data  <= '0;
            dump_addr  <= '0;
            dump_last  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;

            if ((state != IDLE) && stop) begin
                stop_q <= 1'b1;
            end

            if (capture) begin
                dump_data  <= reg_data;
                dump_addr  <= addr;
                dump_last  <= (beat == count_q);
                dump_valid <= 1'b1;
            end

            case (state)
                IDLE: begin
                    stop_q <= 1'b0;
                    if (start) begin
                        first_q  <= first_addr;
                        addr     <= first_addr;
                        reg_addr <= first_addr;
                        count_q  <= count_sat;
                        cont_q   <= continuous;
                        beat     <= {{ADDR_W{1'b0}}, 1'b1};
                        halt_req <= 1'b1;
                        busy     <= 1'b1;
                        state    <= (count_sat == '0) ? FIN : ISSUE;
                    end
                end

                ISSUE: begin
                    wait_cnt <= WAIT_INIT;
                    state    <= (READ_LAT > 0) ? WAIT : OUT;
                end

                WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state <= OUT;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end

                OUT: begin
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        if (!dump_last) begin
                            addr     <= addr + 1'b1;
                            reg_addr <= addr + 1'b1;
                            beat     <= beat + 1'b1;
                            state    <= ISSUE;
                        end else if (cont_q && !stop_q && !stop) begin
                            addr     <= first_q;
                            reg_addr <= first_q;
                            beat     <= {{ADDR_W{1'b0}}, 1'b1};
                            state    <= ISSUE;
                        end else begin
                            state <= FIN;
                        end
                    end
                end

                FIN: begin
                    done     <= 1'b1;
                    halt_req <= 1'b0;
                    busy     <= 1'b0;
                    stop_q   <= 1'b0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reg_dump_ctrl
//   Two controller instances (read latency 0 and 2) share control inputs but
//   have their own start strobe and their own register-file model. A table
//   of dump requests is applied to the selected instance; every beat is
//   compared against addresses and data derived from the request.
// ---------------------------------------------------------------------------
module tb_reg_dump_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start0 = 1'b0, start2 = 1'b0;
    logic          continuous = 1'b0, stop = 1'b0, dump_ready = 1'b0;
    logic [AW-1:0] first_addr = '0;
    logic [AW:0]   count = '0;

    logic [AW-1:0] reg_addr0, reg_addr2, dump_addr0, dump_addr2;
    logic [DW-1:0] reg_data0, reg_data2, dump_data0, dump_data2;
    logic          halt0, halt2, valid0, valid2, last0, last2;
    logic          busy0, busy2, done0, done2;

    always #5 clk = ~clk;

    // Register-file contents: a fixed function of the address.
    function automatic logic [DW-1:0] rf_val(input logic [AW-1:0] a);
        return {8'hC3, 3'b000, a, 8'h96, 3'b000, ~a};
    endfunction

    // Latency-0 file reads combinationally; latency-2 file has two flops.
    logic [DW-1:0] rf_p1 = '0;
    logic [DW-1:0] rf_p2 = '0;
    assign reg_data0 = rf_val(reg_addr0);
    assign reg_data2 = rf_p2;
    always @(posedge clk) begin
        rf_p1 <= rf_val(reg_addr2);
        rf_p2 <= rf_p1;
    end

    reg_dump_ctrl #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .continuous(continuous),
        .stop(stop), .first_addr(first_addr), .count(count),
        .reg_addr(reg_addr0), .reg_data(reg_data0), .halt_req(halt0),
        .dump_valid(valid0), .dump_ready(dump_ready), .dump_data(dump_data0),
        .dump_addr(dump_addr0), .dump_last(last0), .busy(busy0), .done(done0)
    );

    reg_dump_ctrl #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .continuous(continuous),
        .stop(stop), .first_addr(first_addr), .count(count),
        .reg_addr(reg_addr2), .reg_data(reg_data2), .halt_req(halt2),
        .dump_valid(valid2), .dump_ready(dump_ready), .dump_data(dump_data2),
        .dump_addr(dump_addr2), .dump_last(last2), .busy(busy2), .done(done2)
    );

    // Observed instance selected by sel (0: latency 0, 1: latency 2).
    logic          sel = 1'b0;
    logic [AW-1:0] m_raddr, m_addr;
    logic [DW-1:0] m_data;
    logic          m_halt, m_valid, m_last, m_busy, m_done;
    always_comb begin
        m_raddr = reg_addr0; m_addr = dump_addr0; m_data = dump_data0;
        m_halt  = halt0;  m_valid = valid0; m_last = last0;
        m_busy  = busy0;  m_done  = done0;
        if (sel) begin
            m_raddr = reg_addr2; m_addr = dump_addr2; m_data = dump_data2;
            m_halt  = halt2;  m_valid = valid2; m_last = last2;
            m_busy  = busy2;  m_done  = done2;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          sel;        // 1 selects the latency-2 instance
        logic [AW-1:0] first;
        logic [AW:0]   cnt;
        logic          cont;
        logic          toggle;     // dump_ready toggles every cycle
        int            stop_beat;  // pulse stop on first sight of this beat (0: never)
        int            exp_beats;  // total beats expected
        int            exp_pass;   // beats per pass after saturation
        logic [AW-1:0] exp_last;   // address of the final beat
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v, input string tag);
        int            lat;
        int            beats;
        int            done_n;
        int            last_acc;
        logic          held;
        logic [DW-1:0] prev_data;
        logic [AW-1:0] prev_addr, exp_addr, last_seen;
        logic          prev_last;
        lat = v.sel ? 2 : 0;
        beats = 0; done_n = 0; last_acc = 0; held = 1'b0;
        prev_data = '0; prev_addr = '0; prev_last = 1'b0; last_seen = '0;
        sel = v.sel;
        @(negedge clk);
        first_addr = v.first;
        count      = v.cnt;
        continuous = v.cont;
        dump_ready = v.toggle ? 1'b0 : 1'b1;
        if (v.sel) start2 = 1'b1; else start0 = 1'b1;
        for (int n = 1; n <= 400 && done_n == 0; n++) begin
            @(negedge clk);
            start0 = 1'b0; start2 = 1'b0; stop = 1'b0;
            if (n == 1) begin
                check({tag, " busy after start"}, 64'(m_busy), 64'd1);
                check({tag, " halt_req after start"}, 64'(m_halt), 64'd1);
                check({tag, " reg_addr in ISSUE"}, 64'(m_raddr), 64'(v.first));
            end
            if (m_done) done_n = n;
            if (v.toggle) dump_ready = ~dump_ready;
            if (m_valid) begin
                if (held) begin
                    check({tag, " held data"}, 64'(m_data), 64'(prev_data));
                    check({tag, " held addr"}, 64'(m_addr), 64'(prev_addr));
                    check({tag, " held last"}, 64'(m_last), 64'(prev_last));
                end else begin
                    beats++;
                    exp_addr = AW'(int'(v.first) + (beats - 1) % v.exp_pass);
                    if (beats == 1)
                        check({tag, " first valid cycle"}, 64'(n), 64'(2 + lat));
                    check({tag, " beat addr"}, 64'(m_addr), 64'(exp_addr));
                    check({tag, " beat data"}, 64'(m_data), 64'(rf_val(exp_addr)));
                    check({tag, " beat last"}, 64'(m_last), 64'((beats % v.exp_pass) == 0));
                    if (beats == v.stop_beat) stop = 1'b1;
                    last_seen = m_addr;
                end
                prev_data = m_data; prev_addr = m_addr; prev_last = m_last;
                held = !dump_ready;
                if (dump_ready && m_last) last_acc = n;
            end else begin
                held = 1'b0;
            end
        end
        dump_ready = 1'b0;
        check({tag, " done seen (cycle)"}, 64'(done_n), 64'((v.exp_beats == 0) ? 2 : last_acc + 2));
        check({tag, " beat count"}, 64'(beats), 64'(v.exp_beats));
        if (v.exp_beats > 0)
            check({tag, " last beat addr"}, 64'(last_seen), 64'(v.exp_last));
        check({tag, " halt_req with done"}, 64'(m_halt), 64'd0);
        check({tag, " busy with done"}, 64'(m_busy), 64'd0);
        @(negedge clk);
        check({tag, " done one cycle"}, 64'(m_done), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        //            sel   first  cnt    cont  tog   stop beats pass last
        vecs[0] = '{1'b0, 5'd16, 6'd8,  1'b0, 1'b0, 0,   8,    8,   5'd23};
        vecs[1] = '{1'b1, 5'd30, 6'd4,  1'b0, 1'b1, 0,   4,    4,   5'd1 };
        vecs[2] = '{1'b0, 5'd5,  6'd0,  1'b0, 1'b0, 0,   0,    1,   5'd0 };
        vecs[3] = '{1'b0, 5'd8,  6'd2,  1'b1, 1'b0, 3,   4,    2,   5'd9 };
        vecs[4] = '{1'b1, 5'd0,  6'd40, 1'b0, 1'b0, 0,   32,   32,  5'd31};
        vecs[5] = '{1'b0, 5'd31, 6'd1,  1'b0, 1'b1, 0,   1,    1,   5'd31};
        vecs[6] = '{1'b1, 5'd3,  6'd33, 1'b0, 1'b1, 0,   32,   32,  5'd2 };

        // Reset state of both instances.
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("reset valid", 64'(m_valid), 64'd0);
            check("reset data", 64'(m_data), 64'd0);
            check("reset reg_addr", 64'(m_raddr), 64'd0);
            check("reset halt/busy/done", 64'({m_halt, m_busy, m_done}), 64'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while a beat is stalled, then a fresh dump.
        sel = 1'b0;
        @(negedge clk);
        first_addr = 5'd4; count = 6'd6; continuous = 1'b0; dump_ready = 1'b0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int n = 0; n < 20 && !m_valid; n++) @(negedge clk);
        check("stalled beat before reset", 64'(m_valid), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid reset valid", 64'(m_valid), 64'd0);
        check("mid reset data", 64'(m_data), 64'd0);
        check("mid reset addr/reg_addr", 64'({m_addr, m_raddr}), 64'd0);
        check("mid reset halt/busy/done/last", 64'({m_halt, m_busy, m_done, m_last}), 64'd0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("no done during reset", 64'(m_done), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("no done after reset", 64'(m_done), 64'd0);
        run_vec('{1'b0, 5'd10, 6'd3, 1'b0, 1'b0, 0, 3, 3, 5'd12}, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
